gpio_event_detect: RTL and testbench

//  Per-channel event detector that consumes the debounced outputs of the input filter bank.

---
 rtl/gpio_event_pkg.sv | 30 +++
 rtl/gpio_event_chan.sv | 46 ++++
 rtl/gpio_event_detect.sv | 64 ++++++
 tb/tb_gpio_event_detect.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_event_pkg.sv
// Shared types and helpers for the GPIO event detector.
// Provides the event-enable bundle type and the per-bit event qualifier.
package gpio_event_pkg;

    localparam int unsigned DefaultWidth = 32;

    typedef struct packed {
        logic [DefaultWidth-1:0] rise;
        logic [DefaultWidth-1:0] fall;
        logic [DefaultWidth-1:0] lvlhi;
        logic [DefaultWidth-1:0] lvllo;
    } evt_cfg_t;

    // Qualified event for one channel given current and previous sample.
    function automatic logic chan_event(
        input logic data,
        input logic prev,
        input logic en_rise,
        input logic en_fall,
        input logic en_lvlhi,
        input logic en_lvllo
    );
        logic rise;
        logic fall;
        rise = data & ~prev;
        fall = ~data & prev;
        return (rise & en_rise) | (fall & en_fall) | (data & en_lvlhi) | (~data & en_lvllo);
    endfunction

endpackage

// File: rtl/gpio_event_chan.sv
// One channel of the event detector: previous-sample flop and sticky state bit.
module gpio_event_chan
    import gpio_event_pkg::*;
#(
    parameter logic ResetBit = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic data_i,
    input  logic en_rise_i,
    input  logic en_fall_i,
    input  logic en_lvlhi_i,
    input  logic en_lvllo_i,
    input  logic clear_i,
    input  logic test_i,
    output logic data_o,
    output logic state_o,
    output logic event_o
);

    logic data_q;
    logic data_d;
    logic state_q;
    logic state_d;

    always_comb begin
        data_d  = data_i;
        event_o = chan_event(data_i, data_q, en_rise_i, en_fall_i, en_lvlhi_i, en_lvllo_i);
        // Set terms are OR'd after the clear so a simultaneous set wins.
        state_d = (state_q & ~clear_i) | event_o | test_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q  <= ResetBit;
            state_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            state_q <= state_d;
        end
    end

    assign data_o  = data_q;
    assign state_o = state_q;

endmodule

// File: rtl/gpio_event_detect.sv
// Per-channel edge/level event detector with sticky W1C state and a registered,
// masked interrupt line.
module gpio_event_detect
    import gpio_event_pkg::*;
#(
    parameter int unsigned Width = DefaultWidth,
    parameter logic [Width-1:0] ResetValue = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] data_i,
    input  logic [Width-1:0] en_rise_i,
    input  logic [Width-1:0] en_fall_i,
    input  logic [Width-1:0] en_lvlhi_i,
    input  logic [Width-1:0] en_lvllo_i,
    input  logic [Width-1:0] intr_enable_i,
    input  logic [Width-1:0] intr_clear_i,
    input  logic [Width-1:0] intr_test_i,
    output logic [Width-1:0] data_o,
    output logic [Width-1:0] intr_state_o,
    output logic             intr_o
);

    logic [Width-1:0] evt;
    logic [Width-1:0] state_d;
    logic             intr_q;
    logic             intr_d;

    for (genvar i = 0; i < Width; i++) begin : g_chan
        gpio_event_chan #(
            .ResetBit(ResetValue[i])
        ) u_chan (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .data_i    (data_i[i]),
            .en_rise_i (en_rise_i[i]),
            .en_fall_i (en_fall_i[i]),
            .en_lvlhi_i(en_lvlhi_i[i]),
            .en_lvllo_i(en_lvllo_i[i]),
            .clear_i   (intr_clear_i[i]),
            .test_i    (intr_test_i[i]),
            .data_o    (data_o[i]),
            .state_o   (intr_state_o[i]),
            .event_o   (evt[i])
        );
    end

    // Mask against next state so intr_o lines up with intr_state_o.
    always_comb begin
        state_d = (intr_state_o & ~intr_clear_i) | evt | intr_test_i;
        intr_d  = |(state_d & intr_enable_i);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            intr_q <= 1'b0;
        end else begin
            intr_q <= intr_d;
        end
    end

    assign intr_o = intr_q;

endmodule

// File: tb/tb_gpio_event_detect.sv
// Self-checking bench for gpio_event_detect: directed scenarios plus a randomized run,
// all checked against a per-channel behavioural model.
module tb_gpio_event_detect;
    import gpio_event_pkg::*;

    logic        clk_i;
    logic        rst_ni;
    logic [31:0] data_i;
    logic [31:0] intr_enable_i;
    logic [31:0] intr_clear_i;
    logic [31:0] intr_test_i;
    logic [31:0] data_o;
    logic [31:0] intr_state_o;
    logic        intr_o;
    evt_cfg_t    cfg;

    logic [31:0] m_data;
    logic [31:0] m_state;
    logic        m_intr;

    int n_checks = 0;
    int n_fail   = 0;

    gpio_event_detect #(
        .Width     (32),
        .ResetValue(32'h0)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .data_i       (data_i),
        .en_rise_i    (cfg.rise),
        .en_fall_i    (cfg.fall),
        .en_lvlhi_i   (cfg.lvlhi),
        .en_lvllo_i   (cfg.lvllo),
        .intr_enable_i(intr_enable_i),
        .intr_clear_i (intr_clear_i),
        .intr_test_i  (intr_test_i),
        .data_o       (data_o),
        .intr_state_o (intr_state_o),
        .intr_o       (intr_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Advance one clock; the model applies the channel rules to the inputs seen at the edge.
    task automatic tick();
        logic [31:0] ns;
        logic        ni;
        ns = m_state;
        for (int i = 0; i < 32; i++) begin
            bit up, down, ev;
            up   = data_i[i] && !m_data[i];
            down = !data_i[i] && m_data[i];
            ev   = (up && cfg.rise[i]) || (down && cfg.fall[i]) ||
                   (data_i[i] && cfg.lvlhi[i]) || (!data_i[i] && cfg.lvllo[i]);
            if (intr_clear_i[i]) ns[i] = 1'b0;
            if (ev || intr_test_i[i]) ns[i] = 1'b1;
        end
        ni = 1'b0;
        for (int i = 0; i < 32; i++) if (ns[i] && intr_enable_i[i]) ni = 1'b1;
        @(posedge clk_i);
        #1;
        m_data       = data_i;
        m_state      = ns;
        m_intr       = ni;
        intr_clear_i = '0;
        intr_test_i  = '0;
    endtask

    task automatic test_reset();
        rst_ni        = 1'b0;
        data_i        = '0;
        cfg           = '0;
        intr_enable_i = '0;
        intr_clear_i  = '0;
        intr_test_i   = '0;
        m_data = '0; m_state = '0; m_intr = 1'b0;
        repeat (2) @(posedge clk_i);
        #3 rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        n_checks++;
        if (data_o !== 32'h0) begin
            n_fail++; $display("FAIL reset_data got %h want %h", data_o, 32'h0);
        end
        n_checks++;
        if (intr_state_o !== 32'h0) begin
            n_fail++; $display("FAIL reset_state got %h want %h", intr_state_o, 32'h0);
        end
        n_checks++;
        if (intr_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_intr got %b want 0", intr_o);
        end
    endtask

    task automatic test_edge();
        cfg.rise[3]      = 1'b1;
        intr_enable_i[3] = 1'b1;
        repeat (4) tick();
        data_i[3] = 1'b1;
        tick();
        n_checks++;
        if (intr_state_o !== 32'h8) begin
            n_fail++; $display("FAIL edge_state got %h want %h", intr_state_o, 32'h8);
        end
        n_checks++;
        if (intr_o !== 1'b1) begin
            n_fail++; $display("FAIL edge_intr got %b want 1", intr_o);
        end
        n_checks++;
        if (data_o[3] !== 1'b1) begin
            n_fail++; $display("FAIL edge_data got %b want 1", data_o[3]);
        end
    endtask

    task automatic test_clear();
        repeat (3) tick();
        intr_clear_i[3] = 1'b1;
        tick();
        n_checks++;
        if (intr_state_o[3] !== 1'b0 || intr_o !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_bit got state %b intr %b want 0 0", intr_state_o[3], intr_o);
        end
        cfg.lvlhi[3] = 1'b1;
        tick();
        intr_clear_i[3] = 1'b1;
        tick();
        n_checks++;
        if (intr_state_o[3] !== 1'b1 || intr_o !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_level_wins got state %b intr %b want 1 1",
                     intr_state_o[3], intr_o);
        end
        cfg          = '0;
        intr_clear_i = '1;
        tick();
    endtask

    task automatic test_pulse();
        intr_enable_i = '0;
        cfg.rise[7]   = 1'b1;
        cfg.fall[7]   = 1'b1;
        data_i[7] = 1'b1;
        tick();
        data_i[7] = 1'b0;
        tick();
        n_checks++;
        if (intr_state_o[7] !== 1'b1 || intr_o !== 1'b0) begin
            n_fail++;
            $display("FAIL pulse_masked got state %b intr %b want 1 0", intr_state_o[7], intr_o);
        end
        intr_enable_i[7] = 1'b1;
        tick();
        n_checks++;
        if (intr_o !== 1'b1) begin
            n_fail++; $display("FAIL pulse_unmask got intr %b want 1", intr_o);
        end
        cfg          = '0;
        intr_clear_i = '1;
        tick();
    endtask

    task automatic test_no_spurious();
        data_i[0] = 1'b1;
        repeat (20) tick();
        cfg.rise[0] = 1'b1;
        repeat (3) tick();
        n_checks++;
        if (intr_state_o[0] !== 1'b0) begin
            n_fail++; $display("FAIL late_enable got state %b want 0", intr_state_o[0]);
        end
        cfg = '0;
    endtask

    task automatic test_intr_test();
        intr_clear_i = '1;
        tick();
        intr_test_i = 32'h8000_0001;
        tick();
        n_checks++;
        if (intr_state_o !== 32'h8000_0001) begin
            n_fail++; $display("FAIL test_strobe got %h want %h", intr_state_o, 32'h8000_0001);
        end
        intr_clear_i[0] = 1'b1;
        intr_test_i[0]  = 1'b1;
        tick();
        n_checks++;
        if (intr_state_o !== 32'h8000_0001) begin
            n_fail++;
            $display("FAIL test_vs_clear got %h want %h", intr_state_o, 32'h8000_0001);
        end
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int c = 0; c < 400; c++) begin
            data_i = (c % 3 == 0) ? $urandom : (data_i ^ ($urandom & $urandom));
            if (c % 25 == 0) begin
                cfg.rise      = $urandom;
                cfg.fall      = $urandom;
                cfg.lvlhi     = $urandom & $urandom & $urandom;
                cfg.lvllo     = $urandom & $urandom & $urandom;
                intr_enable_i = $urandom & $urandom & $urandom & $urandom;
            end
            intr_clear_i = (c % 4 == 0) ? $urandom : 32'h0;
            intr_test_i  = $urandom & $urandom & $urandom & $urandom;
            tick();
            n_checks++;
            if (intr_state_o !== m_state || intr_o !== m_intr || data_o !== m_data) begin
                n_fail++;
                if (errs < 10)
                    $display("FAIL rand_cycle %0d got st %h intr %b data %h want %h %b %h",
                             c, intr_state_o, intr_o, data_o, m_state, m_intr, m_data);
                errs++;
            end
        end
    endtask

    task automatic test_async_reset();
        cfg           = '0;
        intr_enable_i = '1;
        intr_test_i   = '1;
        tick();
        n_checks++;
        if (intr_state_o !== 32'hFFFF_FFFF || intr_o !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset got %h %b want ffffffff 1", intr_state_o, intr_o);
        end
        #2 rst_ni = 1'b0;
        #1;
        n_checks++;
        if (intr_state_o !== 32'h0 || intr_o !== 1'b0 || data_o !== 32'h0) begin
            n_fail++;
            $display("FAIL async_reset got st %h intr %b data %h want 0 0 0",
                     intr_state_o, intr_o, data_o);
        end
        m_data = '0; m_state = '0; m_intr = 1'b0;
        data_i      = 32'h4;
        cfg.rise[2] = 1'b1;
        #2 rst_ni = 1'b1;
        tick();
        n_checks++;
        if (intr_state_o !== 32'h4 || intr_state_o !== m_state || intr_o !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_edge got st %h intr %b want %h 1",
                     intr_state_o, intr_o, 32'h4);
        end
    endtask

    initial begin
        test_reset();
        test_edge();
        test_clear();
        test_pulse();
        test_no_spurious();
        test_intr_test();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
